// File: rtl/reg_writeback.sv
// Write-back stage ahead of the register stack: buffers execute-stage writes in a
// small FIFO, drains them with a registered set_clk strobe and forwards pending values.
module reg_writeback #(
    parameter int NIB_WIDTH  = 4,
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [NIB_WIDTH-1:0]   wr_num,
    input  logic [WORD_WIDTH-1:0]  wr_val,
    output logic                   wr_ready,
    output logic [NIB_WIDTH-1:0]   setnum,
    output logic [WORD_WIDTH-1:0]  setval,
    output logic                   set_clk,
    input  logic [NIB_WIDTH-1:0]   rd_num1,
    input  logic [NIB_WIDTH-1:0]   rd_num2,
    input  logic [WORD_WIDTH-1:0]  reg_out1,
    input  logic [WORD_WIDTH-1:0]  reg_out2,
    output logic [WORD_WIDTH-1:0]  fwd_out1,
    output logic [WORD_WIDTH-1:0]  fwd_out2,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   idle
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t state, state_next;

    logic [NIB_WIDTH-1:0]  num_mem [DEPTH];
    logic [WORD_WIDTH-1:0] val_mem [DEPTH];
    logic [PTR_W-1:0]      head, tail, head_inc, scan_idx;
    logic [CNT_W-1:0]      count;
    logic                  push, pop, load;
    logic [NIB_WIDTH-1:0]  load_num;
    logic [WORD_WIDTH-1:0] load_val;

    // wr_ready depends only on the registered count, so a pop never opens it early
    assign wr_ready = (count != CNT_W'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop      = (state == HOLD);
    assign head_inc = head + PTR_W'(1);
    assign pending  = count;
    assign idle     = (state == IDLE) && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head_inc;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            num_mem[tail] <= wr_num;
            val_mem[tail] <= wr_val;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_num   = num_mem[head];
        load_val   = val_mem[head];
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP:  state_next = STROBE;
            STROBE: state_next = HOLD;
            HOLD: begin
                state_next = IDLE;
                // With only the head left, a same-cycle push becomes the next head directly
                if (count > CNT_W'(1)) begin
                    load       = 1'b1;
                    state_next = SETUP;
                    load_num   = num_mem[head_inc];
                    load_val   = val_mem[head_inc];
                end else if (push) begin
                    load       = 1'b1;
                    state_next = SETUP;
                    load_num   = wr_num;
                    load_val   = wr_val;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            setnum  <= '0;
            setval  <= '0;
            set_clk <= 1'b0;
        end else begin
            state   <= state_next;
            set_clk <= (state_next == STROBE);
            if (load) begin
                setnum <= load_num;
                setval <= load_val;
            end
        end
    end

    // Oldest-to-newest scan so the newest matching entry overrides older ones
    always_comb begin
        fwd_out1 = reg_out1;
        fwd_out2 = reg_out2;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (num_mem[scan_idx] == rd_num1) fwd_out1 = val_mem[scan_idx];
                if (num_mem[scan_idx] == rd_num2) fwd_out2 = val_mem[scan_idx];
            end
        end
    end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-back stage directly upstream of the register stack.
- Accepts register write requests from the execute stage with a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into the stack's setnum/setval/set_clk port with a glitch-free, registered set_clk strobe that has setup and hold margin.
- Forwards pending, uncommitted values onto the read path so operand reads never see stale stack data.

Parameters:
NIB_WIDTH, 4, width of a register number
WORD_WIDTH, 16, width of a register value
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
wr_valid  input  1  write request present
wr_num  input  NIB_WIDTH  destination register
wr_val  input  WORD_WIDTH  value to write
wr_ready  output  1  FIFO can accept (not full)
setnum  output  NIB_WIDTH  to stack setnum
setval  output  WORD_WIDTH  to stack setval
set_clk  output  1  to stack set_clk (registered strobe)
rd_num1  input  NIB_WIDTH  operand 1 register number (same as stack num1)
rd_num2  input  NIB_WIDTH  operand 2 register number (same as stack num2)
reg_out1  input  WORD_WIDTH  stack out1
reg_out2  input  WORD_WIDTH  stack out2
fwd_out1  output  WORD_WIDTH  forwarded operand 1
fwd_out2  output  WORD_WIDTH  forwarded operand 2
pending  output  clog2(DEPTH)+1  entries held, including the one being drained
idle  output  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset, asynchronous:
  - FIFO emptied; all pending writes discarded.
  - pending=0, idle=1, wr_ready=1.
  - setnum=0, setval=0, set_clk=0, FSM=IDLE.
  - set_clk drops immediately, including mid-strobe.
- Push: on a clk rising edge with wr_valid&&wr_ready, {wr_num,wr_val} is written at the tail.
- wr_ready=(pending!=DEPTH). A pop in the same cycle does not raise wr_ready. No combinational path from pop to wr_ready.
- The head entry stays in the FIFO until its strobe completes. It counts in pending and stays visible to forwarding throughout.
- Drain FSM, states IDLE, SETUP, STROBE, HOLD:
  - IDLE: if pending!=0, load setnum/setval from head and go to SETUP; set_clk=0.
  - SETUP: set_clk=0, setnum/setval stable; next state STROBE.
  - STROBE: set_clk=1 for exactly one clk cycle; next state HOLD.
  - HOLD: set_clk=0, setnum/setval unchanged. At exit, pop the head. If entries remain after the pop, load the new head and go to SETUP; else go to IDLE. setnum/setval retain their last values in IDLE.
- All of setnum, setval and set_clk are flop outputs.
- Timing:
  - Push at edge N into an empty idle block: SETUP after edge N+1, set_clk high after edge N+2, low after edge N+3, pop at edge N+4.
  - Single-write latency from push to set_clk rise: 2 cycles.
  - Back-to-back throughput: one write per 3 cycles.
- Forwarding is combinational:
  - fwd_outK = value of the newest FIFO entry whose num == rd_numK, else reg_outK.
  - Match scan covers only occupied entries, head through tail-1, in pointer order with wrap-around.
  - Duplicate destinations are legal; newest wins. Both ports may match the same entry.
  - An entry pushed at edge N forwards from just after edge N.
- A push and a pop in the same cycle are both honoured; pending is unchanged.
- Register 0 has no special treatment.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. pending disambiguates full from empty.
- idle=(state==IDLE)&&(pending==0).

Test Plan:
- Reset, then a single push of num=3, val=0x1234 with reg_out1=0 and rd_num1=3:
  - fwd_out1=0x1234 from the cycle after the push.
  - set_clk is high for exactly 1 cycle, 2 cycles after the push, with setnum=3 and setval=0x1234 stable one cycle before and one cycle after the strobe.
  - pending returns to 0 and idle=1.
- Push three writes back-to-back: (1,0x11), (2,0x22), (1,0x33):
  - set_clk rises on a 3-cycle pitch, in order 1, 2, 1.
  - While (1,0x33) is pending, rd_num1=1 gives fwd_out1=0x33 (newest wins).
  - rd_num2=2 gives fwd_out2=0x22 until its pop.
- Hold wr_valid high for 6 cycles with DEPTH=4:
  - wr_ready falls after the 4th accept; no 5th entry is accepted while full.
  - wr_ready rises only after the first pop completes; all 4 values reach the stack in order.
- Wrap-around: run 10 pushes interleaved with drains so the pointers wrap twice. Forwarded values and the stack write order match the push order.
- Assert reset in the cycle set_clk=1 with 2 entries pending:
  - set_clk goes 0 without waiting for a clk edge.
  - pending=0 and idle=1; no further strobes after release.
  - fwd_out1 equals reg_out1.
- No pending entry matches: rd_num1=5, rd_num2=5, reg_out1=reg_out2=0xBEEF with FIFO holding num 4 only -> fwd_out1=fwd_out2=0xBEEF.
